// File: rtl/pdm_wave_gen_pkg.sv
// -----------------------------------------------------------------------------
// pdm_wave_gen_pkg
//   Definitions shared by the PDM sample generator and the PDM modulator core.
//   The modulator input width, the midscale park level and the waveform codes
//   must stay identical on both sides of the pdm_input / write_en link.
// -----------------------------------------------------------------------------
package pdm_wave_gen_pkg;

    // Default widths; the sample width must equal the modulator input width.
    localparam int DEF_SAMPLE_W = 5;
    localparam int DEF_PHASE_W  = 16;
    localparam int DEF_DIV_W    = 8;

    // Level written when the generator parks (half of full scale).
    localparam int MIDSCALE = 16;

    typedef enum logic [1:0] {
        WAVE_SAW = 2'b00,
        WAVE_SQR = 2'b01,
        WAVE_TRI = 2'b10,
        WAVE_DC  = 2'b11
    } wave_t;

endpackage

// File: rtl/pdm_wave_gen_if.sv
// -----------------------------------------------------------------------------
// pdm_wave_gen_if
//   Control and sample bus of the PDM sample generator.
//   master : the controller side (drives enable/wave_sel/freq_word/rate_div and
//            receives sample_out/write_en, i.e. the modulator-facing pins)
//   slave  : the generator side (pdm_wave_gen)
//   Signals:
//     enable      1 = generate samples, 0 = park at midscale
//     wave_sel    waveform select (saw, square, triangle, DC)
//     freq_word   phase increment per sample tick; low bits are the DC level
//     rate_div    sample tick every rate_div+1 cycles
//     sample_out  sample to the modulator (pdm_input)
//     write_en    one-cycle strobe qualifying sample_out
// -----------------------------------------------------------------------------
interface pdm_wave_gen_if
    import pdm_wave_gen_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int PHASE_W  = DEF_PHASE_W,
    parameter int DIV_W    = DEF_DIV_W
) ();

    logic                enable;
    wave_t               wave_sel;
    logic [PHASE_W-1:0]  freq_word;
    logic [DIV_W-1:0]    rate_div;
    logic [SAMPLE_W-1:0] sample_out;
    logic                write_en;

    modport master (
        output enable,
        output wave_sel,
        output freq_word,
        output rate_div,
        input  sample_out,
        input  write_en
    );

    modport slave (
        input  enable,
        input  wave_sel,
        input  freq_word,
        input  rate_div,
        output sample_out,
        output write_en
    );

endinterface

// File: rtl/pdm_wave_shaper.sv
// -----------------------------------------------------------------------------
// pdm_wave_shaper
//   Combinational mapping from the top bits of the phase accumulator to a
//   sample value.
//   Ports:
//     phase_msb  in   SAMPLE_W+1  top SAMPLE_W+1 bits of the phase (P)
//     wave_sel   in   wave_t      waveform select
//     level      in   SAMPLE_W    DC level
//     sample     out  SAMPLE_W    shaped sample
//   P[SAMPLE_W] is the half-period flag; the bits below it are the position
//   inside the half period.
// -----------------------------------------------------------------------------
module pdm_wave_shaper
    import pdm_wave_gen_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W
) (
    input  logic [SAMPLE_W:0]   phase_msb,
    input  wave_t               wave_sel,
    input  logic [SAMPLE_W-1:0] level,
    output logic [SAMPLE_W-1:0] sample
);

    always_comb begin
        sample = level;
        case (wave_sel)
            WAVE_SAW: sample = phase_msb[SAMPLE_W:1];
            WAVE_SQR: sample = phase_msb[SAMPLE_W] ? '1 : '0;
            // Second half period counts down by inverting the position bits.
            WAVE_TRI: sample = phase_msb[SAMPLE_W] ? ~phase_msb[SAMPLE_W-1:0]
                                                   :  phase_msb[SAMPLE_W-1:0];
            WAVE_DC:  sample = level;
            default:  sample = level;
        endcase
    end

endmodule

// File: rtl/pdm_wave_gen.sv
// -----------------------------------------------------------------------------
// pdm_wave_gen
//   Upstream sample source for the PDM modulator core. A programmable divider
//   produces sample ticks; each tick advances a phase accumulator and the
//   shaped sample is written to the modulator with a one-cycle strobe.
//   Ports:
//     Clock    in   1   single clock, rising edge (shared with the modulator)
//     nReset   in   1   synchronous reset, active-low
//     bus      slave    enable / wave_sel / freq_word / rate_div in,
//                       sample_out / write_en out (pdm_input / write_en)
//   Timing: the tick is decided in the cycle it occurs (_p0); the phase update
//   and the registered sample/strobe appear one cycle later (_p1).
//   The widths must match those of the connected interface instance.
// -----------------------------------------------------------------------------
module pdm_wave_gen
    import pdm_wave_gen_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int PHASE_W  = DEF_PHASE_W,
    parameter int DIV_W    = DEF_DIV_W
) (
    input  logic           Clock,
    input  logic           nReset,
    pdm_wave_gen_if.slave  bus
);

    localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(MIDSCALE);

    logic [DIV_W-1:0]    div_cnt_p0;
    logic [PHASE_W-1:0]  phase_p0;
    logic                en_q_p0;

    logic                tick_p0;
    logic                park_p0;
    logic [PHASE_W-1:0]  phase_adv_p0;
    logic [SAMPLE_W-1:0] shaped_p0;

    logic [SAMPLE_W-1:0] sample_p1;
    logic                vld_p1;

    // ---- stage p0: divider tick, enable edge, next phase and its shape ----
    always_comb begin
        // >= (not ==) so a lowered rate_div ticks immediately instead of
        // waiting for the counter to wrap.
        tick_p0 = bus.enable && (div_cnt_p0 >= bus.rate_div);
        park_p0 = en_q_p0 && !bus.enable;
        // DC mode holds the phase so a later switch back resumes in place.
        phase_adv_p0 = (bus.wave_sel == WAVE_DC) ? phase_p0
                                                 : phase_p0 + bus.freq_word;
    end

    pdm_wave_shaper #(
        .SAMPLE_W (SAMPLE_W)
    ) u_shaper (
        .phase_msb (phase_adv_p0[PHASE_W-1 -: SAMPLE_W+1]),
        .wave_sel  (bus.wave_sel),
        .level     (bus.freq_word[SAMPLE_W-1:0]),
        .sample    (shaped_p0)
    );

    // ---- stage p1: accumulator update and registered sample/strobe ----
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            div_cnt_p0 <= '0;
            phase_p0   <= '0;
            en_q_p0    <= 1'b0;
            sample_p1  <= MID;
            vld_p1     <= 1'b0;
        end else begin
            en_q_p0 <= bus.enable;
            vld_p1  <= 1'b0;

            if (!bus.enable || tick_p0) begin
                div_cnt_p0 <= '0;
            end else begin
                div_cnt_p0 <= div_cnt_p0 + DIV_W'(1);
            end

            // The park write takes priority; a tick cannot coincide with it
            // because ticks need enable=1, so the phase is left untouched.
            if (park_p0) begin
                sample_p1 <= MID;
                vld_p1    <= 1'b1;
            end else if (tick_p0) begin
                phase_p0  <= phase_adv_p0;
                sample_p1 <= shaped_p0;
                vld_p1    <= 1'b1;
            end
        end
    end

    assign bus.sample_out = sample_p1;
    assign bus.write_en   = vld_p1;

endmodule

// File: tb/tb_pdm_wave_gen.sv
// -----------------------------------------------------------------------------
// tb_pdm_wave_gen
//   Self-checking bench for pdm_wave_gen. A behavioural reference model of the
//   generator's rules predicts sample_out/write_en after every clock edge.
// -----------------------------------------------------------------------------
module tb_pdm_wave_gen;
    import pdm_wave_gen_pkg::*;

    logic Clock;
    logic nReset;

    pdm_wave_gen_if bus ();

    pdm_wave_gen dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_phase = 0;
    int m_cnt   = 0;
    int m_enq   = 0;
    int m_out   = 16;
    int m_we    = 0;

    // Sample value for a 16-bit phase, from the waveform definitions.
    function automatic int shape(int ph, int ws, int fw);
        int p;
        p = (ph >> 10) & 63;
        case (ws)
            0:       return p / 2;
            1:       return (p >= 32) ? 31 : 0;
            2:       return (p >= 32) ? 31 - (p - 32) : p;
            default: return fw % 32;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: inputs present before the edge are applied to the model,
    // outputs are compared 1 time unit after the edge.
    task automatic step(string tag);
        int rst_n, en, ws, fw, rd;
        rst_n = int'(nReset);
        en    = int'(bus.enable);
        ws    = int'(bus.wave_sel);
        fw    = int'(bus.freq_word);
        rd    = int'(bus.rate_div);
        @(posedge Clock);
        if (rst_n == 0) begin
            m_phase = 0; m_cnt = 0; m_enq = 0; m_out = MIDSCALE; m_we = 0;
        end else begin
            m_we = 0;
            if (m_enq == 1 && en == 0) begin
                m_out = MIDSCALE;
                m_we  = 1;
            end else if (en == 1 && m_cnt >= rd) begin
                if (ws != 3) m_phase = (m_phase + fw) % 65536;
                m_out = shape(m_phase, ws, fw);
                m_we  = 1;
            end
            m_cnt = (en == 1 && m_cnt < rd) ? m_cnt + 1 : 0;
            m_enq = en;
        end
        #1;
        check({tag, ".we"},  32'(bus.write_en),   32'(m_we));
        check({tag, ".out"}, 32'(bus.sample_out), 32'(m_out));
    endtask

    initial begin
        int strobes;
        int guard;
        int saved_phase;

        // 1. Reset with enable high
        nReset        = 1'b0;
        bus.enable    = 1'b1;
        bus.wave_sel  = WAVE_SAW;
        bus.freq_word = 16'h0800;
        bus.rate_div  = 8'd3;
        step("reset0");
        step("reset1");
        check("reset_out", 32'(bus.sample_out), 32'd16);
        check("reset_we",  32'(bus.write_en),   32'd0);
        nReset = 1'b1;
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            step("post_reset");
            strobes += int'(bus.write_en);
        end
        check("no_early_strobe", 32'(strobes), 32'd0);
        step("first_tick");
        check("first_tick_we",  32'(bus.write_en),   32'd1);
        check("first_tick_out", 32'(bus.sample_out), 32'd1);

        // 2. Saw at maximum rate: one strobe per cycle, wraps 31 -> 0
        bus.rate_div = 8'd0;
        strobes = 0;
        for (int i = 0; i < 32; i++) begin
            step("saw");
            strobes += int'(bus.write_en);
        end
        check("saw_strobes", 32'(strobes), 32'd32);
        check("saw_wrap", 32'(bus.sample_out), 32'd1);

        // 3. Divider: 1 strobe per 4 cycles, then lowered rate takes effect at once
        bus.rate_div = 8'd3;
        strobes = 0;
        for (int i = 0; i < 8; i++) begin
            step("div4");
            strobes += int'(bus.write_en);
        end
        check("div4_strobes", 32'(strobes), 32'd2);
        step("div_cnt1");
        step("div_cnt2");
        bus.rate_div = 8'd1;
        step("rate_drop");
        check("rate_drop_tick", 32'(bus.write_en), 32'd1);
        strobes = 0;
        for (int i = 0; i < 6; i++) begin
            step("div2");
            strobes += int'(bus.write_en);
        end
        check("div2_strobes", 32'(strobes), 32'd3);

        // 4. Triangle and square from phase 0
        nReset = 1'b0;
        step("tri_reset");
        nReset        = 1'b1;
        bus.rate_div  = 8'd0;
        bus.freq_word = 16'h0400;
        bus.wave_sel  = WAVE_TRI;
        for (int i = 0; i < 64; i++) step("tri");
        nReset = 1'b0;
        step("sqr_reset");
        nReset       = 1'b1;
        bus.wave_sel = WAVE_SQR;
        for (int i = 0; i < 64; i++) step("sqr");

        // 5. Enable drop on a tick cycle: park write, phase retained
        bus.wave_sel  = WAVE_SAW;
        bus.freq_word = 16'h0800;
        bus.rate_div  = 8'd2;
        step("pre_drop");
        guard = 0;
        while (m_cnt < 2 && guard < 10) begin
            step("seek_tick");
            guard++;
        end
        check("seek_tick_bound", 32'(guard < 10), 32'd1);
        saved_phase = m_phase;
        bus.enable = 1'b0;
        step("park");
        check("park_we",  32'(bus.write_en),   32'd1);
        check("park_out", 32'(bus.sample_out), 32'd16);
        bus.enable = 1'b1;
        step("reen0");
        step("reen1");
        check("reen_quiet", 32'(bus.write_en), 32'd0);
        step("resume");
        check("resume_we",  32'(bus.write_en), 32'd1);
        check("resume_out", 32'(bus.sample_out),
              32'(((saved_phase + 16'h0800) % 65536) >> 11));

        // 6. DC level 7 (upper freq_word bits ignored), then reset before strobe
        bus.wave_sel  = WAVE_DC;
        bus.freq_word = 16'hA5E7;
        bus.rate_div  = 8'd1;
        strobes = 0;
        for (int i = 0; i < 8; i++) begin
            step("dc");
            if (bus.write_en) check("dc_level", 32'(bus.sample_out), 32'd7);
            strobes += int'(bus.write_en);
        end
        check("dc_strobes", 32'(strobes), 32'd4);
        guard = 0;
        while (m_cnt < 1 && guard < 10) begin
            step("dc_seek");
            guard++;
        end
        nReset = 1'b0;
        step("mid_reset");
        check("mid_reset_we",  32'(bus.write_en),   32'd0);
        check("mid_reset_out", 32'(bus.sample_out), 32'd16);
        nReset = 1'b1;

        // 7. Randomised operation against the model
        for (int i = 0; i < 400; i++) begin
            nReset        = ($urandom_range(0, 59) != 0);
            bus.enable    = ($urandom_range(0, 7) != 0);
            bus.wave_sel  = wave_t'($urandom_range(0, 3));
            bus.freq_word = 16'($urandom);
            bus.rate_div  = 8'($urandom_range(0, 4));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
